// File: rtl/sar_adc_pkg.sv
// Shared definitions for the SAR oversampling sequencer.
//   - FSM state encoding, both as an enum and as plain 2-bit constants.
//   - Default result width of the SAR controller.
//   - round_avg(): round-half-up divide of an accumulator by 2**avg_log2.
package sar_adc_pkg;

  localparam int ADC_BITS_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_GAP  = 2'd2
  } sar_state_e;

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_CONV = S_CONV;
  localparam logic [1:0] ST_GAP  = S_GAP;

  // With avg_log2 == 0 there is no rounding term and the sample passes through.
  function automatic logic [31:0] round_avg(input logic [31:0] acc, input int avg_log2);
    logic [31:0] half;
    half = (avg_log2 > 0) ? (32'd1 << (avg_log2 - 1)) : 32'd0;
    return (acc + half) >> avg_log2;
  endfunction

endpackage

// File: rtl/sar_avg_accum.sv
// Accumulate / average datapath for the SAR oversampling sequencer.
// Sums 2**AVG_LOG2 captured results, publishes the rounded average on a
// valid/ready stream and flags overwritten (unaccepted) averages.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   capture_i       take result_i into the accumulator this edge
//   discard_i       drop the partial burst (acc/cnt cleared)
//   result_i        SAR result
//   avg_ready_i     downstream accept
//   clr_err_i       sync clear of overrun_o (wins over a set)
//   avg_data_o      rounded average
//   avg_valid_o     avg_data_o valid, held until accepted
//   overrun_o       sticky: unaccepted average was overwritten
module sar_avg_accum
  import sar_adc_pkg::*;
#(
  parameter int ADC_BITS = ADC_BITS_DEF,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                capture_i,
  input  logic                discard_i,
  input  logic [ADC_BITS-1:0] result_i,
  input  logic                avg_ready_i,
  input  logic                clr_err_i,
  output logic [ADC_BITS-1:0] avg_data_o,
  output logic                avg_valid_o,
  output logic                overrun_o
);

  localparam int ACC_W = ADC_BITS + AVG_LOG2;
  // A zero-width counter is illegal; with AVG_LOG2 == 0 the 1-bit counter
  // stays at 0 so every capture ends a burst.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (AVG_LOG2 > 0) ? CNT_W'((1 << AVG_LOG2) - 1) : '0;

  logic [ACC_W-1:0]    acc_q, acc_d, acc_next;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADC_BITS-1:0] avg_data_q, avg_data_d;
  logic                avg_valid_q, avg_valid_d;
  logic                overrun_q, overrun_d;
  logic                burst_done;

  assign acc_next   = acc_q + ACC_W'(result_i);
  assign burst_done = capture_i && (cnt_q == CNT_LAST);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_data_d  = avg_data_q;
    avg_valid_d = avg_valid_q;
    overrun_d   = overrun_q;

    if (discard_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (capture_i) begin
      if (burst_done) begin
        acc_d      = '0;
        cnt_d      = '0;
        // Rounded mean of ADC_BITS-wide samples always fits in ADC_BITS.
        avg_data_d = ADC_BITS'(round_avg(32'(acc_next), AVG_LOG2));
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (avg_valid_q && avg_ready_i) avg_valid_d = 1'b0;
    if (burst_done) avg_valid_d = 1'b1;

    if (burst_done && avg_valid_q && !avg_ready_i) overrun_d = 1'b1;
    if (clr_err_i) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_data_q  <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_data_q  <= avg_data_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign avg_data_o  = avg_data_q;
  assign avg_valid_o = avg_valid_q;
  assign overrun_o   = overrun_q;

endmodule

// File: rtl/sar_oversample_sequencer.sv
// SAR oversampling sequencer: drives the SAR controller go/valid handshake,
// runs back-to-back conversions while run=1 and emits one rounded average of
// 2**AVG_LOG2 results per burst on a valid/ready stream.
// Optional feature macro: SAR_TIMEOUT_EN (conversion watchdog, TIMEOUT_CYCLES).
// Ports:
//   clk, rst_n         clock, async active-low reset
//   run                level, keep converting
//   adc_go             registered go to SAR controller
//   adc_valid          SAR result valid (only looked at in CONV)
//   adc_result         SAR result
//   avg_data/avg_valid averaged result stream, avg_ready accepts
//   overrun            sticky overwrite flag
//   timeout_err        sticky watchdog flag (tied 0 without SAR_TIMEOUT_EN)
//   clr_err            sync clear of both sticky flags
//   busy               state != IDLE
//
// state | meaning
// IDLE  | not converting, adc_go low
// CONV  | adc_go high, waiting for adc_valid
// GAP   | adc_go low for one cycle so the controller re-arms; stale valid ignored
module sar_oversample_sequencer
  import sar_adc_pkg::*;
#(
  parameter int ADC_BITS       = ADC_BITS_DEF,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                adc_go,
  input  logic                adc_valid,
  input  logic [ADC_BITS-1:0] adc_result,
  output logic [ADC_BITS-1:0] avg_data,
  output logic                avg_valid,
  input  logic                avg_ready,
  output logic                overrun,
  output logic                timeout_err,
  input  logic                clr_err,
  output logic                busy
);

  if (AVG_LOG2 < 0 || AVG_LOG2 > 6 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sar_oversample_sequencer: AVG_LOG2 must be 0..6 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0] state_q, state_d;
  logic       adc_go_q, adc_go_d;
  logic       capture, discard;
  logic       tmo_hit;

`ifdef SAR_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmo_err_q, tmo_err_d;

  // Down-counter loaded on CONV entry; reaching zero in CONV marks the
  // TIMEOUT_CYCLES-th cycle without a result.
  assign tmo_hit = (state_q == ST_CONV) && (tmr_q == '0);

  always_comb begin
    tmr_d = tmr_q;
    if (state_d == ST_CONV && state_q != ST_CONV) tmr_d = TMR_LOAD;
    else if (state_q == ST_CONV && tmr_q != '0)   tmr_d = tmr_q - TMR_W'(1);

    tmo_err_d = tmo_err_q;
    if (tmo_hit && run && !adc_valid) tmo_err_d = 1'b1;
    if (clr_err) tmo_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    adc_go_d = adc_go_q;
    capture  = 1'b0;
    discard  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d  = ST_CONV;
          adc_go_d = 1'b1;
        end
      end
      ST_CONV: begin
        // A run drop aborts even if a result arrives on the same edge.
        if (!run) begin
          state_d  = ST_IDLE;
          adc_go_d = 1'b0;
          discard  = 1'b1;
        end else if (adc_valid) begin
          state_d  = ST_GAP;
          adc_go_d = 1'b0;
          capture  = 1'b1;
        end else if (tmo_hit) begin
          state_d  = ST_GAP;
          adc_go_d = 1'b0;
          discard  = 1'b1;
        end
      end
      ST_GAP: begin
        adc_go_d = run;
        state_d  = run ? ST_CONV : ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        adc_go_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      adc_go_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      adc_go_q <= adc_go_d;
    end
  end

  sar_avg_accum #(
    .ADC_BITS (ADC_BITS),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture_i   (capture),
    .discard_i   (discard),
    .result_i    (adc_result),
    .avg_ready_i (avg_ready),
    .clr_err_i   (clr_err),
    .avg_data_o  (avg_data),
    .avg_valid_o (avg_valid),
    .overrun_o   (overrun)
  );

  assign adc_go = adc_go_q;
  assign busy   = (state_q != ST_IDLE);

endmodule
